// File: rtl/int_pipe_if.sv
// Signal bundle between the integer pipe and its dispatch / register-file environment.
// The pipe uses the slave view; dispatch plus register file use the master view.
interface int_pipe_if #(
    parameter int WIDTH = 16,
    parameter int SELW  = 3
);
    logic [3:0]       OP;
    logic [SELW-1:0]  ASEL;
    logic [SELW-1:0]  BSEL;
    logic [SELW-1:0]  CSEL;
    logic [SELW-1:0]  RA_SEL;
    logic [WIDTH-1:0] RA_DAT;
    logic [SELW-1:0]  RB_SEL;
    logic [WIDTH-1:0] RB_DAT;
    logic             WEN;
    logic [SELW-1:0]  WSEL;
    logic [WIDTH-1:0] WDAT;
    logic             WB_HOLD;
    logic             BUSY;
    logic             ZF;
    logic             NF;
    logic             CF;

    modport master (
        output OP, ASEL, BSEL, CSEL, RA_DAT, RB_DAT, WB_HOLD,
        input  RA_SEL, RB_SEL, WEN, WSEL, WDAT, BUSY, ZF, NF, CF
    );

    modport slave (
        input  OP, ASEL, BSEL, CSEL, RA_DAT, RB_DAT, WB_HOLD,
        output RA_SEL, RB_SEL, WEN, WSEL, WDAT, BUSY, ZF, NF, CF
    );
endinterface

// File: rtl/int_pipe.sv
// Three-stage integer pipe (ID -> EX -> WB) with EX/WB result forwarding into ID
// and a writeback port that can be held off by the register file arbiter.
module int_pipe #(
    parameter int WIDTH  = 16,
    parameter int SELW   = 3,
    parameter bit MUL_EN = 1'b1
) (
    input  logic      CLK,
    input  logic      RST,
    int_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_SAR = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_INC = 4'd11;
    localparam logic [3:0] OP_DEC = 4'd12;
    localparam logic [3:0] OP_MOV = 4'd13;

    // ID stage
    logic             idValid;
    logic [3:0]       idOp;
    logic [SELW-1:0]  idASel;
    logic [SELW-1:0]  idBSel;
    logic [SELW-1:0]  idCSel;

    // EX stage
    logic             exValid;
    logic [3:0]       exOp;
    logic [SELW-1:0]  exCSel;
    logic [WIDTH-1:0] exA;
    logic [WIDTH-1:0] exB;

    // WB stage
    logic             wbValid;
    logic [SELW-1:0]  wbSel;
    logic [WIDTH-1:0] wbDat;
    logic             zfReg;
    logic             nfReg;
    logic             cfReg;

    logic             stall;
    logic             opLegal;
    logic [WIDTH-1:0] fwdA;
    logic [WIDTH-1:0] fwdB;
    logic [WIDTH-1:0] aluRes;
    logic             aluCarry;

    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   addExt;
    logic [WIDTH:0]   subExt;
    logic [WIDTH:0]   incExt;
    logic [WIDTH:0]   decExt;
    logic [WIDTH:0]   shlExt;
    logic [WIDTH:0]   shrExt;
    logic [WIDTH:0]   sarExt;
    logic [WIDTH-1:0] mulLow;

    // A held writeback freezes the whole pipe; a hold with WB empty has no effect.
    assign stall    = wbValid & bus.WB_HOLD;
    assign bus.BUSY = stall;

    assign bus.RA_SEL = idASel;
    assign bus.RB_SEL = idBSel;

    always_comb begin
        opLegal = 1'b0;
        case (bus.OP)
            OP_NOP:  opLegal = 1'b0;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
            OP_SHL, OP_SHR, OP_SAR, OP_INC, OP_DEC, OP_MOV:
                     opLegal = 1'b1;
            OP_MUL:  opLegal = MUL_EN;
            default: opLegal = 1'b0;
        endcase
    end

    // Per-operand bypass: the younger EX result beats WB, which beats the register file.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic [SELW-1:0]  srcSel;
            logic [WIDTH-1:0] rfDat;
            logic [WIDTH-1:0] fwd;

            assign srcSel = (gi == 0) ? idASel     : idBSel;
            assign rfDat  = (gi == 0) ? bus.RA_DAT : bus.RB_DAT;

            always_comb begin
                if (exValid && (exCSel == srcSel)) begin
                    fwd = aluRes;
                end else if (wbValid && (wbSel == srcSel)) begin
                    fwd = wbDat;
                end else begin
                    fwd = rfDat;
                end
            end

            if (gi == 0) begin : g_a
                assign fwdA = fwd;
            end else begin : g_b
                assign fwdB = fwd;
            end
        end
    endgenerate

    // Extended-width forms carry the carry/borrow/shifted-out bit in the spare position.
    assign shamt  = exB[SHW-1:0];
    assign addExt = {1'b0, exA} + {1'b0, exB};
    assign subExt = {1'b0, exA} - {1'b0, exB};
    assign incExt = {1'b0, exA} + {{WIDTH{1'b0}}, 1'b1};
    assign decExt = {1'b0, exA} - {{WIDTH{1'b0}}, 1'b1};
    assign shlExt = {1'b0, exA} << shamt;
    assign shrExt = {exA, 1'b0} >> shamt;
    assign sarExt = $signed({exA, 1'b0}) >>> shamt;

    generate
        if (MUL_EN) begin : g_mul
            assign mulLow = exA * exB;
        end else begin : g_nomul
            assign mulLow = '0;
        end
    endgenerate

    always_comb begin
        aluRes   = '0;
        aluCarry = 1'b0;
        case (exOp)
            OP_ADD: begin aluRes = addExt[WIDTH-1:0]; aluCarry = addExt[WIDTH]; end
            OP_SUB: begin aluRes = subExt[WIDTH-1:0]; aluCarry = subExt[WIDTH]; end
            OP_AND: aluRes = exA & exB;
            OP_OR:  aluRes = exA | exB;
            OP_XOR: aluRes = exA ^ exB;
            OP_NOT: aluRes = ~exA;
            OP_SHL: begin aluRes = shlExt[WIDTH-1:0]; aluCarry = shlExt[WIDTH]; end
            OP_SHR: begin aluRes = shrExt[WIDTH:1];   aluCarry = shrExt[0];     end
            OP_SAR: begin aluRes = sarExt[WIDTH:1];   aluCarry = sarExt[0];     end
            OP_MUL: aluRes = mulLow;
            OP_INC: begin aluRes = incExt[WIDTH-1:0]; aluCarry = incExt[WIDTH]; end
            OP_DEC: begin aluRes = decExt[WIDTH-1:0]; aluCarry = decExt[WIDTH]; end
            OP_MOV: aluRes = exA;
            default: begin
                aluRes   = '0;
                aluCarry = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idValid <= 1'b0;
            idOp    <= '0;
            idASel  <= '0;
            idBSel  <= '0;
            idCSel  <= '0;
        end else if (!stall) begin
            idValid <= opLegal;
            idOp    <= bus.OP;
            idASel  <= bus.ASEL;
            idBSel  <= bus.BSEL;
            idCSel  <= bus.CSEL;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            exValid <= 1'b0;
            exOp    <= '0;
            exCSel  <= '0;
            exA     <= '0;
            exB     <= '0;
        end else if (!stall) begin
            exValid <= idValid;
            exOp    <= idOp;
            exCSel  <= idCSel;
            exA     <= fwdA;
            exB     <= fwdB;
        end
    end

    // Bubbles entering WB leave the last result, its index and its flags in place.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wbValid <= 1'b0;
            wbSel   <= '0;
            wbDat   <= '0;
            zfReg   <= 1'b0;
            nfReg   <= 1'b0;
            cfReg   <= 1'b0;
        end else if (!stall) begin
            wbValid <= exValid;
            if (exValid) begin
                wbSel <= exCSel;
                wbDat <= aluRes;
                zfReg <= (aluRes == '0);
                nfReg <= aluRes[WIDTH-1];
                cfReg <= aluCarry;
            end
        end
    end

    assign bus.WEN  = wbValid;
    assign bus.WSEL = wbSel;
    assign bus.WDAT = wbDat;
    assign bus.ZF   = zfReg;
    assign bus.NF   = nfReg;
    assign bus.CF   = cfReg;
endmodule

// File: tb/tb_int_pipe.sv
// Bench for int_pipe: directed vectors and hazard sequences, then random traffic
// scored against an in-order architectural model of the register file.
module tb_int_pipe;
    localparam int WIDTH = 16;
    localparam int SELW  = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int_pipe_if #(.WIDTH(WIDTH), .SELW(SELW)) bus ();
    int_pipe_if #(.WIDTH(WIDTH), .SELW(SELW)) bus2 ();

    int_pipe #(.WIDTH(WIDTH), .SELW(SELW), .MUL_EN(1'b1)) dut (
        .CLK(CLK), .RST(RST), .bus(bus)
    );
    int_pipe #(.WIDTH(WIDTH), .SELW(SELW), .MUL_EN(1'b0)) dutNoMul (
        .CLK(CLK), .RST(RST), .bus(bus2)
    );

    // Register file seen by the main pipe; preload is used only while the pipe is idle.
    logic [15:0] rf [8];
    logic [15:0] preload [8];
    logic        loadReq = 1'b0;
    int          writeCount = 0;

    always @(posedge CLK) begin
        if (loadReq) begin
            for (int i = 0; i < 8; i++) rf[i] <= preload[i];
        end else if (bus.WEN && !bus.WB_HOLD) begin
            rf[bus.WSEL] <= bus.WDAT;
            writeCount   <= writeCount + 1;
        end
    end
    assign bus.RA_DAT  = rf[bus.RA_SEL];
    assign bus.RB_DAT  = rf[bus.RB_SEL];
    assign bus2.RA_DAT = 16'd3;
    assign bus2.RB_DAT = 16'd3;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural reference: plain integer arithmetic on the operand values.
    function automatic void refOp(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic wr, output logic [15:0] res, output logic cOut);
        int ua, ub, s, r, sa;
        ua = int'(a); ub = int'(b); s = ub % 16; r = 0; cOut = 1'b0; wr = 1'b1;
        sa = (ua >= 32768) ? ua - 65536 : ua;
        case (op)
            4'd1:  begin r = ua + ub; cOut = (r > 65535); end
            4'd2:  begin r = ua - ub; cOut = (ua < ub); end
            4'd3:  r = ua & ub;
            4'd4:  r = ua | ub;
            4'd5:  r = ua ^ ub;
            4'd6:  r = 65535 - ua;
            4'd7:  begin r = ua * (1 << s); cOut = (s != 0) && (((ua >> (16 - s)) & 1) == 1); end
            4'd8:  begin r = ua >> s;       cOut = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
            4'd9:  begin r = sa >>> s;      cOut = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
            4'd10: r = int'((longint'(ua) * longint'(ub)) % 64'sd65536);
            4'd11: begin r = ua + 1; cOut = (ua == 65535); end
            4'd12: begin r = ua - 1; cOut = (ua == 0); end
            4'd13: r = ua;
            default: wr = 1'b0;
        endcase
        res = r[15:0];
    endfunction

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] dat;
        logic        z, n, c;
    } wr_t;

    logic [15:0] modelRegs [8];
    wr_t         expQ [$];

    task automatic issueModel(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                              input logic [2:0] c);
        logic wr, cOut;
        logic [15:0] res;
        wr_t e;
        refOp(op, modelRegs[a], modelRegs[b], wr, res, cOut);
        if (wr) begin
            modelRegs[c] = res;
            e.sel = c; e.dat = res; e.z = (res == 16'd0); e.n = res[15]; e.c = cOut;
            expQ.push_back(e);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] c);
        bus.OP = op; bus.ASEL = a; bus.BSEL = b; bus.CSEL = c;
    endtask

    task automatic loadRegs();
        drive(4'd0, 3'd0, 3'd0, 3'd0);
        @(negedge CLK);
        loadReq = 1'b1;
        @(negedge CLK);
        loadReq = 1'b0;
        for (int i = 0; i < 8; i++) modelRegs[i] = preload[i];
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a, b;
        logic        wen;
        logic [15:0] dat;
        logic        z, n, c;
    } vec_t;

    vec_t vecs [20];

    initial begin
        logic        wenSeen, w1, w2, pending;
        logic [3:0]  pOp;
        logic [2:0]  pA, pB, pC;
        int          wc0;
        wr_t         e;
        logic [3:0]  fOp  [10];
        logic [2:0]  fA   [10];
        logic [2:0]  fB   [10];
        logic [2:0]  fC   [10];
        logic [15:0] fExp [10];

        vecs[0]  = '{4'd1,  16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{4'd2,  16'h0001, 16'hFFFF, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{4'd3,  16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{4'd4,  16'h8000, 16'h0001, 1'b1, 16'h8001, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{4'd5,  16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{4'd6,  16'h00FF, 16'h0000, 1'b1, 16'hFF00, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{4'd7,  16'h8001, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{4'd8,  16'h8001, 16'h0001, 1'b1, 16'h4000, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{4'd9,  16'h8001, 16'h0001, 1'b1, 16'hC000, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{4'd10, 16'h0100, 16'h0100, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{4'd10, 16'h0003, 16'h0005, 1'b1, 16'h000F, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{4'd11, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{4'd12, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{4'd13, 16'h7FFF, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{4'd7,  16'h1234, 16'h0010, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{4'd9,  16'h8000, 16'h000F, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{4'd8,  16'h0001, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{4'd14, 16'h1111, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{4'd15, 16'h1111, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{4'd2,  16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b1};

        drive(4'd0, 3'd0, 3'd0, 3'd0);
        bus.WB_HOLD = 1'b0;
        bus2.OP = 4'd0; bus2.ASEL = 3'd1; bus2.BSEL = 3'd2; bus2.CSEL = 3'd3; bus2.WB_HOLD = 1'b0;

        // Reset held with random dispatch traffic and hold requests
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            drive(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 3'($urandom));
            bus.WB_HOLD = 1'($urandom_range(0, 1));
            #1;
            check("reset_outputs", 32'({bus.WEN, bus.BUSY, bus.ZF, bus.NF, bus.CF, bus.WSEL, bus.WDAT}), 32'd0);
        end
        @(negedge CLK);
        RST = 1'b0;
        drive(4'd0, 3'd0, 3'd0, 3'd0);
        bus.WB_HOLD = 1'b0;
        wenSeen = 1'b0;
        repeat (5) begin @(negedge CLK); #1; wenSeen |= bus.WEN; end
        check("post_reset_nop_wen", 32'(wenSeen), 32'd0);

        // Single-op vectors: latency and per-op result/flags
        for (int v = 0; v < 20; v++) begin
            for (int i = 0; i < 8; i++) preload[i] = 16'h0;
            preload[1] = vecs[v].a; preload[2] = vecs[v].b;
            loadRegs();
            drive(vecs[v].op, 3'd1, 3'd2, 3'd3);
            @(negedge CLK); drive(4'd0, 3'd0, 3'd0, 3'd0); #1; w1 = bus.WEN;
            @(negedge CLK); #1; w2 = bus.WEN;
            @(negedge CLK); #1;
            check($sformatf("vec%0d_wen_timing", v), 32'({w1, w2, bus.WEN}), 32'({2'b00, vecs[v].wen}));
            if (vecs[v].wen) begin
                check($sformatf("vec%0d_wsel", v), 32'(bus.WSEL), 32'd3);
                check($sformatf("vec%0d_wdat", v), 32'(bus.WDAT), 32'(vecs[v].dat));
                check($sformatf("vec%0d_flags", v), 32'({bus.ZF, bus.NF, bus.CF}),
                      32'({vecs[v].z, vecs[v].n, vecs[v].c}));
            end
            $display("vec %0d op=%0d a=%h b=%h -> wen=%0b wdat=%h zf=%0b nf=%0b cf=%0b",
                     v, vecs[v].op, vecs[v].a, vecs[v].b, bus.WEN, bus.WDAT, bus.ZF, bus.NF, bus.CF);
            @(negedge CLK);
        end
        check("latency_regfile_r3", 32'(rf[3]), 32'hFFFE);

        // Back-to-back dependent ops, same-register operands, EX-over-WB priority
        for (int i = 0; i < 8; i++) preload[i] = 16'hAAAA;
        preload[1] = 16'd5; preload[2] = 16'd3;
        loadRegs();
        fOp = '{4'd1, 4'd2, 4'd5, 4'd1, 4'd11, 4'd11, 4'd13, 4'd0, 4'd0, 4'd0};
        fA  = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd1,  3'd1,  3'd1,  3'd0, 3'd0, 3'd0};
        fB  = '{3'd2, 3'd2, 3'd3, 3'd5, 3'd0,  3'd0,  3'd0,  3'd0, 3'd0, 3'd0};
        fC  = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd1,  3'd1,  3'd2,  3'd0, 3'd0, 3'd0};
        fExp = '{16'd8, 16'd5, 16'd13, 16'd26, 16'd6, 16'd7, 16'd7, 16'd0, 16'd0, 16'd0};
        for (int t = 0; t < 10; t++) begin
            if (t > 0) @(negedge CLK);
            drive(fOp[t], fA[t], fB[t], fC[t]);
            #1;
            if (t >= 3) begin
                check($sformatf("fwd%0d_wen", t - 3), 32'(bus.WEN), 32'd1);
                check($sformatf("fwd%0d_wsel", t - 3), 32'(bus.WSEL), 32'(fC[t - 3]));
                check($sformatf("fwd%0d_wdat", t - 3), 32'(bus.WDAT), 32'(fExp[t - 3]));
                $display("fwd write %0d: r%0d <= %h", t - 3, bus.WSEL, bus.WDAT);
            end
        end
        drive(4'd0, 3'd0, 3'd0, 3'd0);
        @(negedge CLK);

        // Writeback held for three cycles with a full pipe
        for (int i = 0; i < 8; i++) preload[i] = 16'h0;
        preload[1] = 16'd5; preload[2] = 16'd3;
        loadRegs();
        drive(4'd1, 3'd1, 3'd2, 3'd3);
        @(negedge CLK); drive(4'd2, 3'd1, 3'd2, 3'd4);
        @(negedge CLK); drive(4'd3, 3'd1, 3'd2, 3'd5);
        @(negedge CLK); drive(4'd4, 3'd1, 3'd2, 3'd6);
        bus.WB_HOLD = 1'b1;
        wc0 = writeCount;
        for (int t = 0; t < 3; t++) begin
            if (t > 0) @(negedge CLK);
            #1;
            check($sformatf("stall%0d_busy", t), 32'(bus.BUSY), 32'd1);
            check($sformatf("stall%0d_wb", t), 32'({bus.WEN, bus.WSEL, bus.WDAT}), 32'({1'b1, 3'd3, 16'd8}));
        end
        @(negedge CLK);
        bus.WB_HOLD = 1'b0;
        #1;
        check("stall_release_busy", 32'(bus.BUSY), 32'd0);
        check("stall_release_wb", 32'({bus.WEN, bus.WSEL, bus.WDAT}), 32'({1'b1, 3'd3, 16'd8}));
        check("stall_no_write_while_held", 32'(writeCount - wc0), 32'd0);
        @(negedge CLK); drive(4'd0, 3'd0, 3'd0, 3'd0); #1;
        check("stall_single_write", 32'(writeCount - wc0), 32'd1);
        check("resume0", 32'({bus.WEN, bus.WSEL, bus.WDAT}), 32'({1'b1, 3'd4, 16'd2}));
        @(negedge CLK); #1;
        check("resume1", 32'({bus.WEN, bus.WSEL, bus.WDAT}), 32'({1'b1, 3'd5, 16'd1}));
        @(negedge CLK); #1;
        check("resume2", 32'({bus.WEN, bus.WSEL, bus.WDAT}), 32'({1'b1, 3'd6, 16'd7}));
        @(negedge CLK); #1;
        check("resume_drained_wen", 32'(bus.WEN), 32'd0);
        check("stall_regs", 32'({rf[3][7:0], rf[4][7:0], rf[5][7:0], rf[6][7:0]}), 32'h08020107);
        $display("stall sequence: writes=%0d r3=%h r4=%h r5=%h r6=%h", writeCount - wc0, rf[3], rf[4], rf[5], rf[6]);

        // Randomized traffic with random writeback holds against the model
        for (int i = 0; i < 8; i++) preload[i] = 16'($urandom);
        loadRegs();
        pending = 1'b0; pOp = 4'd0; pA = 3'd0; pB = 3'd0; pC = 3'd0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge CLK);
            bus.WB_HOLD = (cyc < 390) && ($urandom_range(0, 3) == 0);
            if (!pending) begin
                if (cyc < 360) begin
                    pOp = 4'($urandom_range(0, 15));
                    pA = 3'($urandom); pB = 3'($urandom); pC = 3'($urandom);
                end else begin
                    pOp = 4'd0;
                end
                pending = 1'b1;
            end
            drive(pOp, pA, pB, pC);
            #1;
            if (bus.WEN && !bus.WB_HOLD) begin
                if (expQ.size() == 0) begin
                    check("rand_unexpected_write", 32'(bus.WEN), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    check("rand_wsel", 32'(bus.WSEL), 32'(e.sel));
                    check("rand_wdat", 32'(bus.WDAT), 32'(e.dat));
                    check("rand_flags", 32'({bus.ZF, bus.NF, bus.CF}), 32'({e.z, e.n, e.c}));
                    $display("rand write: r%0d <= %h zf=%0b nf=%0b cf=%0b", bus.WSEL, bus.WDAT, bus.ZF, bus.NF, bus.CF);
                end
            end
            if (!bus.BUSY && pending) begin
                issueModel(pOp, pA, pB, pC);
                pending = 1'b0;
            end
        end
        check("rand_drained", 32'(expQ.size()), 32'd0);
        for (int i = 0; i < 8; i++) check($sformatf("rand_reg%0d", i), 32'(rf[i]), 32'(modelRegs[i]));

        // Reset pulsed between edges while stalled with three ops in flight
        for (int i = 0; i < 8; i++) preload[i] = 16'h0;
        preload[1] = 16'd5; preload[2] = 16'd3;
        loadRegs();
        drive(4'd1, 3'd1, 3'd2, 3'd3);
        @(negedge CLK); drive(4'd2, 3'd1, 3'd2, 3'd4);
        @(negedge CLK); drive(4'd3, 3'd1, 3'd2, 3'd5);
        @(negedge CLK); bus.WB_HOLD = 1'b1; #1;
        check("rstmid_busy_before", 32'(bus.BUSY), 32'd1);
        RST = 1'b1;
        #1;
        check("rstmid_busy_wen", 32'({bus.BUSY, bus.WEN}), 32'd0);
        #2;
        RST = 1'b0;
        bus.WB_HOLD = 1'b0;
        drive(4'd0, 3'd0, 3'd0, 3'd0);
        wc0 = writeCount;
        wenSeen = 1'b0;
        repeat (5) begin @(negedge CLK); #1; wenSeen |= bus.WEN; end
        check("rstmid_no_wen", 32'(wenSeen), 32'd0);
        check("rstmid_no_writes", 32'({writeCount - wc0, rf[3]}), 32'd0);
        $display("reset mid-op: writes after reset=%0d r3=%h", writeCount - wc0, rf[3]);

        // Multiply-disabled build: op 10 is a NOP, other ops still write
        @(negedge CLK); bus2.OP = 4'd10;
        wenSeen = 1'b0;
        @(negedge CLK); bus2.OP = 4'd0;
        repeat (4) begin @(negedge CLK); #1; wenSeen |= bus2.WEN; end
        check("nomul_op10_wen", 32'(wenSeen), 32'd0);
        bus2.OP = 4'd1;
        @(negedge CLK); bus2.OP = 4'd0;
        @(negedge CLK);
        @(negedge CLK); #1;
        check("nomul_add_wb", 32'({bus2.WEN, bus2.WSEL, bus2.WDAT}), 32'({1'b1, 3'd3, 16'd6}));
        $display("nomul: add wen=%0b wsel=%0d wdat=%h", bus2.WEN, bus2.WSEL, bus2.WDAT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
